// File: rtl/dac_frame_serializer.sv
// I2S DAC serializer: buffers stereo pairs in a small FIFO and shifts them out on dacdat,
// timed by the codec's bclk/daclrck, which are synchronized and edge-detected in the clk domain.
module dac_frame_serializer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          bclk,
    input  logic                          daclrck,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_left,
    input  logic [DATA_W-1:0]             s_right,
    output logic                          dacdat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic [CNT_W-1:0]              underrun_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_PAD   = 2'd3;

    logic                  bclk_sync1_r, bclk_sync2_r, bclk_prev_r;
    logic                  lr_sync1_r, lr_sync2_r, lr_prev_r;
    logic                  bclk_fall_s, lr_fall_s, lr_rise_s;
    logic                  frame_start_s, fifo_empty_s, push_s, pop_s;
    logic [LVL_W-1:0]      level_next_s;
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [2*DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic [2*DATA_W-1:0]   head_s;
    logic [1:0]            state_r;
    logic [DATA_W-1:0]     shreg_r, hold_r_r;
    logic [BIT_W-1:0]      bit_cnt_r;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_sync1_r <= 1'b0;
            bclk_sync2_r <= 1'b0;
            bclk_prev_r  <= 1'b0;
            lr_sync1_r   <= 1'b0;
            lr_sync2_r   <= 1'b0;
            lr_prev_r    <= 1'b0;
        end else begin
            bclk_sync1_r <= bclk;
            bclk_sync2_r <= bclk_sync1_r;
            bclk_prev_r  <= bclk_sync2_r;
            lr_sync1_r   <= daclrck;
            lr_sync2_r   <= lr_sync1_r;
            lr_prev_r    <= lr_sync2_r;
        end
    end

    assign bclk_fall_s   = bclk_prev_r & ~bclk_sync2_r;
    assign lr_fall_s     = lr_prev_r & ~lr_sync2_r;
    assign lr_rise_s     = ~lr_prev_r & lr_sync2_r;
    assign frame_start_s = lr_fall_s & enable;
    assign fifo_empty_s  = (fifo_level == LVL_W'(0));
    assign push_s        = s_valid & s_ready;
    assign pop_s         = frame_start_s & ~fifo_empty_s;
    assign head_s        = mem_r[rd_ptr_r];

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        level_next_s = fifo_level;
        case ({push_s, pop_s})
            2'b10:   level_next_s = fifo_level + LVL_W'(1);
            2'b01:   level_next_s = fifo_level - LVL_W'(1);
            default: level_next_s = fifo_level;
        endcase
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_level <= {LVL_W{1'b0}};
            s_ready    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            fifo_level <= level_next_s;
            s_ready    <= (level_next_s != LVL_W'(FIFO_DEPTH));
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {s_left, s_right};
        end
    end

    // Underrun pulse and saturating counter
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun       <= 1'b0;
            underrun_count <= {CNT_W{1'b0}};
        end else begin
            underrun <= frame_start_s & fifo_empty_s;
            if (frame_start_s && fifo_empty_s && (underrun_count != {CNT_W{1'b1}})) begin
                underrun_count <= underrun_count + CNT_W'(1);
            end
        end
    end

    // Serializer FSM; an lr edge outranks a coincident bclk fall
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            shreg_r   <= {DATA_W{1'b0}};
            hold_r_r  <= {DATA_W{1'b0}};
            bit_cnt_r <= {BIT_W{1'b0}};
            dacdat    <= 1'b0;
        end else if (!enable) begin
            state_r <= ST_IDLE;
            dacdat  <= 1'b0;
        end else if (lr_fall_s) begin
            state_r   <= ST_DELAY;
            bit_cnt_r <= {BIT_W{1'b0}};
            shreg_r   <= pop_s ? head_s[2*DATA_W-1:DATA_W] : {DATA_W{1'b0}};
            hold_r_r  <= pop_s ? head_s[DATA_W-1:0] : {DATA_W{1'b0}};
        end else if (lr_rise_s && (state_r != ST_IDLE)) begin
            state_r   <= ST_DELAY;
            bit_cnt_r <= {BIT_W{1'b0}};
            shreg_r   <= hold_r_r;
        end else if (bclk_fall_s) begin
            case (state_r)
                ST_IDLE: begin
                    dacdat <= 1'b0;
                end
                ST_DELAY: begin
                    dacdat    <= shreg_r[DATA_W-1];
                    shreg_r   <= {shreg_r[DATA_W-2:0], 1'b0};
                    bit_cnt_r <= BIT_W'(1);
                    state_r   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bit_cnt_r == BIT_W'(DATA_W)) begin
                        dacdat  <= 1'b0;
                        state_r <= ST_PAD;
                    end else begin
                        dacdat    <= shreg_r[DATA_W-1];
                        shreg_r   <= {shreg_r[DATA_W-2:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                ST_PAD: begin
                    dacdat <= 1'b0;
                end
                default: begin
                    dacdat  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
